fir_uart_tap: RTL and testbench
===============================

# fir_uart_tap

Downstream tap on the FIR output stream that decimates the per-clock filtered samples and ships them off-chip as 8N1 UART frames. It sits between the FIR output and a spare IO pin of the tile top: the top drives `uio_out[0]` from `tx` and sets `uio_oe[0]=1`. Decimated samples are buffered in a small FIFO. Samples arriving while the FIFO is full are dropped and flagged.

## Interface
- `DECIM`, default 16: keep one sample out of every `DECIM` enabled cycles. Must be ≥ 1.
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit. Must be ≥ 2.
- `FIFO_DEPTH`, default 4: sample buffer depth. Must be a power of two ≥ 2.

Ports:
- `clk`, in, 1: single clock domain.
- `rst_n`, in, 1: reset, synchronous, active-low. Sampled only on the rising edge of `clk`.
- `en`, in, 1: advances the decimation counter when high.
- `y`, in, 8: FIR output sample, valid every cycle.
- `tx`, out, 1: UART line, registered, idles high.
- `busy`, out, 1: high while a frame is on the line.
- `overflow`, out, 1: sticky; set when a sample is dropped.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: number of samples currently held in the FIFO.

## Operation
- **Decimation counter `dcnt`** runs 0..DECIM-1.
  - It increments only when `en=1`.
  - At `dcnt==DECIM-1` with `en=1`, the edge captures `y` (push) and wraps `dcnt` to 0.
  - When `en=0`, `dcnt` holds. The FIFO and transmitter keep running.
- **FIFO** is first-in first-out.
  - Push while full: the sample is dropped, `overflow` is set, and FIFO contents are unchanged.
  - `overflow` is cleared only by reset.
  - Push and pop in the same cycle: both take effect and the count is unchanged. This also applies when the FIFO is full, because the pop frees the slot.
- **TX FSM** states:
  - IDLE: `tx=1`. If the FIFO is not empty: pop, load the shift register, clear the bit timer, go to START.
  - START: `tx=0` for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles. A 3-bit index tracks the bit; after bit 7, go to STOP.
  - STOP: `tx=1` for CLKS_PER_BIT cycles, then go to IDLE.
- `busy = (state != IDLE)`.
- The bit timer counts 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide.
- Sustained loss-free operation requires DECIM ≥ 10·CLKS_PER_BIT+1. Lower ratios overflow by design; this is not an error in the block.

## Timing
- **Reset values:** `tx=1`, `busy=0`, `overflow=0`, `fifo_count=0`, `dcnt=0`, state IDLE.
- **Reset mid-frame:** the frame is aborted at the reset edge. `tx=1` is applied at that edge and the FIFO is emptied.
- **Capture latency:** let E0 be the capture edge.
  - `fifo_count` increments after E0.
  - At E1, IDLE pops. `tx` goes low and `busy` goes high after E1.
- **First capture:** occurs at the DECIM-th enabled edge after reset.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles of START+DATA+STOP.
- **Back-to-back frames:** there is always one IDLE cycle between frames, so the frame period is 10·CLKS_PER_BIT+1 cycles.
- **Empty FIFO in IDLE:** no pop occurs and `tx` stays 1.

## Structure
- Package `fir_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t`
  - `localparam int SAMPLE_W = 8`
- Sub-module `fir_sample_fifo`:
  - Synchronous FIFO with `rst_n`, `push`, `din`, `pop`, `dout`, `full`, `empty`, `count`.
  - `dout` shows the head entry combinationally.
  - Read and write pointers are $clog2(DEPTH)+1 bits wide.
- `fir_uart_tap` contains the decimation counter, the overflow flag and the TX FSM.

## Test plan
1. **Reset:** `rst_n=0` for 2 cycles with `en=1` and `y` toggling → `tx=1`, `busy=0`, `overflow=0`, `fifo_count=0`, and no push occurs.
2. **Single frame** (DECIM=64, CLKS_PER_BIT=4): `y=8'hA5` held, `en=1`.
   - Capture occurs at the 64th edge.
   - One cycle later, `tx=0` for 4 cycles.
   - Data bits follow as 1,0,1,0,0,1,0,1, 4 cycles each.
   - Stop bit high for 4 cycles, then `busy` falls.
3. **Decimation** (DECIM=4, CLKS_PER_BIT=2): `y` is a ramp with `y=k` before edge k, starting at k=0 → transmitted bytes are 8'h03, 8'h07, 8'h0B in order.
4. **Overflow** (DECIM=4, CLKS_PER_BIT=4, FIFO_DEPTH=4), ramp input → `fifo_count` reaches 4, `overflow` rises and stays high, and the transmitted sequence is strictly increasing but with gaps.
5. **Enable gating:** pull `en=0` for 10 cycles when `dcnt=1` → capture is delayed by exactly 10 cycles; an in-flight frame continues unchanged.
6. **Reset mid-frame:** `rst_n=0` for 1 cycle during DATA bit 3 with 2 samples queued → `tx=1` and `busy=0` after that edge, `fifo_count=0`, and no further frame starts until the next capture.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and widths for the FIR output UART tap.
package fir_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int SAMPLE_W = 8;
endpackage

// File: rtl/fir_sample_fifo.sv
// Small synchronous sample FIFO; extra pointer bit separates full from empty.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [SAMPLE_W-1:0]       din,
  input  logic                      pop,
  output logic [SAMPLE_W-1:0]       dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [AW:0]         wptr_q, wptr_d;
  logic [AW:0]         rptr_q, rptr_d;
  logic                do_push, do_pop;

  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = mem_q[rptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fir_uart_tap.sv
// Decimates the FIR output stream, buffers samples and sends them as 8N1 UART frames.
module fir_uart_tap
  import fir_pkg::*;
#(
  parameter int DECIM        = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [SAMPLE_W-1:0]            y,
  output logic                           tx,
  output logic                           busy,
  output logic                           overflow,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);
  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int TMR_W  = $clog2(CLKS_PER_BIT);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);

  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic                ovf_q, ovf_d;
  tx_state_t           state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [2:0]          bit_q, bit_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d;
  logic                tx_q, tx_d;

  logic                push, pop, fifo_full, fifo_empty, tmr_last;
  logic [SAMPLE_W-1:0] fifo_dout;

  assign push = en && (dcnt_q == DCNT_LAST);

  always_comb begin
    dcnt_d = dcnt_q;
    if (en) dcnt_d = push ? '0 : dcnt_q + DCNT_W'(1);
  end

  // Only a push that finds no room, even after a same-cycle pop, is a drop.
  assign ovf_d = ovf_q | (push & fifo_full & ~pop);

  fir_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (y),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tmr_last = (tmr_q == TMR_LAST);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (state_q == IDLE) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        shreg_d = fifo_dout;
        tmr_d   = '0;
        tx_d    = 1'b0;
        state_d = START;
      end
    end else begin
      tmr_d = tmr_last ? '0 : tmr_q + TMR_W'(1);
      if (tmr_last) begin
        // Bit 0 of the shift register is always the bit currently on the line.
        case (state_q)
          START: begin
            state_d = DATA;
            bit_d   = 3'd0;
            tx_d    = shreg_q[0];
          end
          DATA: begin
            if (bit_q == 3'd7) begin
              state_d = STOP;
              tx_d    = 1'b1;
            end else begin
              bit_d   = bit_q + 3'd1;
              shreg_d = shreg_q >> 1;
              tx_d    = shreg_q[1];
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dcnt_q  <= '0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      dcnt_q  <= dcnt_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;
endmodule

// File: tb/tb_fir_uart_tap.sv
// Randomised and directed bench for fir_uart_tap against a frame-level behavioural model.
module tb_fir_uart_tap;
  localparam int DECIM = 4;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n, en;
  logic [7:0]    y;
  logic          tx, busy, overflow;
  logic [CW-1:0] fifo_count;

  fir_uart_tap #(.DECIM(DECIM), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .y          (y),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  // Model: sample queue, enabled-edge counter and a frame clock m_t over 10*CPB cycles.
  byte unsigned mq[$];
  byte unsigned sent[$];
  int           m_dcnt = 0;
  bit           m_ovf  = 0;
  bit           m_act  = 0;
  int           m_t    = 0;
  byte unsigned m_byte = 0;

  function automatic logic m_line();
    int pos;
    if (!m_act) return 1'b1;
    pos = m_t / CPB;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return m_byte[pos-1];
  endfunction

  task automatic model_edge();
    bit cap;
    if (!rst_n) begin
      mq.delete();
      m_dcnt = 0; m_ovf = 0; m_act = 0; m_t = 0;
      return;
    end
    cap = en && (m_dcnt == DECIM - 1);
    if (m_act) begin
      m_t++;
      if (m_t == 10 * CPB) m_act = 0;
    end else if (mq.size() > 0) begin
      m_byte = mq.pop_front();
      sent.push_back(m_byte);
      m_act = 1;
      m_t = 0;
    end
    if (cap) begin
      if (mq.size() < DEPTH) mq.push_back(y);
      else m_ovf = 1;
    end
    if (en) m_dcnt = cap ? 0 : m_dcnt + 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("tx", tx, m_line());
      check("busy", busy, m_act);
      check("overflow", overflow, m_ovf);
      check("fifo_count", fifo_count, mq.size());
    end
  end

  initial begin
    int k, n, mx;
    bit inc, gap, ok;
    logic [9:0] frame;

    // Reset with en high and y toggling
    rst_n = 1'b0; en = 1'b1; y = 8'h55;
    tick();
    chk_on = 1;
    y = 8'hAA;
    tick();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_count", fifo_count, 0);

    // Ramp: decimation order, then overflow with gaps
    rst_n = 1'b1; en = 1'b1; sent.delete(); k = 0; y = 8'(k); mx = 0;
    for (int c = 0; c < 250; c++) begin
      tick();
      k++;
      y = 8'(k);
      if (int'(fifo_count) > mx) mx = int'(fifo_count);
    end
    ok = (sent.size() >= 6);
    check("ramp_sent_n", ok, 1);
    if (ok) begin
      check("dec_b0", sent[0], 8'h03);
      check("dec_b1", sent[1], 8'h07);
      check("dec_b2", sent[2], 8'h0B);
      check("ovf_b4", sent[4], 8'h13);
      check("ovf_b5", sent[5], 8'h2F);
      inc = 1; gap = 0;
      for (int i = 1; i < sent.size(); i++) begin
        if (sent[i] <= sent[i-1]) inc = 0;
        if (int'(sent[i]) - int'(sent[i-1]) > DECIM) gap = 1;
      end
      check("ovf_incr", inc, 1);
      check("ovf_gap", gap, 1);
    end
    check("ovf_maxcount", mx, DEPTH);
    check("ovf_flag", overflow, 1);

    // Single A5 frame
    rst_n = 1'b0; tick();
    rst_n = 1'b1; en = 1'b1; y = 8'hA5;
    repeat (4) tick();
    check("a5_count", fifo_count, 1);
    check("a5_idle", busy, 0);
    en = 1'b0;
    frame = 10'b1101001010;
    for (int p = 0; p < 10; p++) begin
      ok = 1;
      for (int s = 0; s < CPB; s++) begin
        tick();
        if (tx !== frame[p] || busy !== 1'b1) ok = 0;
      end
      check($sformatf("a5_pos%0d", p), ok, 1);
    end
    tick();
    check("a5_end_busy", busy, 0);
    check("a5_end_tx", tx, 1);

    // Enable gating at dcnt==1
    rst_n = 1'b0; tick();
    rst_n = 1'b1; en = 1'b1; y = 8'h3C; n = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      n++;
      if (busy) break;
      if (n == 1) en = 1'b0;
      if (n == 11) en = 1'b1;
    end
    check("gate_busy_edge", n, 15);

    // Reset mid-frame during data bit 3 with two samples queued
    rst_n = 1'b0; tick();
    rst_n = 1'b1; en = 1'b1; k = 0; y = 8'h10;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      k++; y = 8'(8'h10 + k);
      if (busy && fifo_count == 2) begin ok = 1; break; end
    end
    check("mid_fill", ok, 1);
    en = 1'b0;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      if (m_act && m_t >= 4 * CPB && m_t < 5 * CPB) begin ok = 1; break; end
      tick();
    end
    check("mid_reach_bit3", ok, 1);
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    check("mid_tx", tx, 1);
    check("mid_busy", busy, 0);
    check("mid_count", fifo_count, 0);
    ok = 1;
    repeat (30) begin
      tick();
      if (busy !== 1'b0) ok = 0;
    end
    check("mid_quiet", ok, 1);
    en = 1'b1;
    repeat (5) tick();
    check("mid_next_frame", busy, 1);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom_range(3) != 0);
      y     = 8'($urandom);
      rst_n = ($urandom_range(499) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
